// File: rtl/atm_bank_pkg.sv
// Shared constants for the ATM bank host: opcodes, status codes, default widths,
// the power-on account table and the FSM state encoding.
package atm_bank_pkg;

  localparam int NUM_ACCTS_DEF = 3;
  localparam int DATA_W_DEF    = 12;
  localparam int AMT_W_DEF     = 6;

  localparam logic [2:0] OP_DEPOSIT  = 3'b000;
  localparam logic [2:0] OP_WITHDRAW = 3'b001;
  localparam logic [2:0] OP_BALANCE  = 3'b010;
  localparam logic [2:0] OP_TRANSFER = 3'b011;
  localparam logic [2:0] OP_VERIFY   = 3'b100;

  localparam logic [2:0] STAT_OK       = 3'd0;
  localparam logic [2:0] STAT_NO_ACCT  = 3'd1;
  localparam logic [2:0] STAT_BAD_PIN  = 3'd2;
  localparam logic [2:0] STAT_INSUFF   = 3'd3;
  localparam logic [2:0] STAT_NO_DST   = 3'd4;
  localparam logic [2:0] STAT_OVERFLOW = 3'd5;
  localparam logic [2:0] STAT_BAD_OP   = 3'd6;
  localparam logic [2:0] STAT_LOCKED   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_EXEC,
    S_RESP
  } state_e;

  // Power-on table contents; the PIN of each account equals its number.
  function automatic logic [DATA_W_DEF-1:0] rst_acct(input int i);
    case (i)
      0:       return 12'h123;
      1:       return 12'h456;
      2:       return 12'h789;
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W_DEF-1:0] rst_bal(input int i);
    case (i)
      0:       return 12'h457;
      1:       return 12'h8AE;
      2:       return 12'hD05;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/atm_acct_match.sv
// Combinational N-entry account comparator: reports a hit and the lowest matching index.
module atm_acct_match #(
  parameter int N     = 3,
  parameter int W     = 12,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     accts [N],
  input  logic [W-1:0]     key,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    // Walk downwards so the lowest matching entry is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (accts[i] == key) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/atm_bank_host.sv
// Account-server responder for the ATM transaction interface (IDLE/LOOKUP/EXEC/RESP).
// Optional per-account bad-PIN lockout is enabled with `define ATM_BANK_LOCKOUT_EN.
module atm_bank_host
  import atm_bank_pkg::*;
#(
  parameter int NUM_ACCTS = NUM_ACCTS_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int AMT_W     = AMT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_acct,
  input  logic [DATA_W-1:0] req_pin,
  input  logic [DATA_W-1:0] req_dst,
  input  logic [AMT_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_balance,
  output logic [DATA_W-1:0] rsp_dst_balance
);

  localparam int IDX_W = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;

  state_e state, state_nxt;

  logic [DATA_W-1:0] tbl_acct [NUM_ACCTS];
  logic [DATA_W-1:0] tbl_pin  [NUM_ACCTS];
  logic [DATA_W-1:0] tbl_bal  [NUM_ACCTS];

  logic [2:0]        op_q;
  logic [DATA_W-1:0] acct_q, pin_q, dst_q;
  logic [AMT_W-1:0]  amt_q;

  logic             src_hit, dst_hit, src_hit_q, dst_hit_q;
  logic [IDX_W-1:0] src_idx, dst_idx, src_idx_q, dst_idx_q;

  atm_acct_match #(.N(NUM_ACCTS), .W(DATA_W), .IDX_W(IDX_W)) u_src_match (
    .accts(tbl_acct), .key(acct_q), .hit(src_hit), .idx(src_idx)
  );

  atm_acct_match #(.N(NUM_ACCTS), .W(DATA_W), .IDX_W(IDX_W)) u_dst_match (
    .accts(tbl_acct), .key(dst_q), .hit(dst_hit), .idx(dst_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !rst;
        if (req_valid) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  logic              src_locked;
  logic              pin_ok, bad_op, amt_zero;
  logic [DATA_W:0]   src_ext, dst_ext, amt_ext, src_sum, src_diff, dst_sum;
  logic [2:0]        exec_status;
  logic [DATA_W-1:0] new_src, new_dst, exec_dst_bal;
  logic              wr_src, wr_dst;

  assign pin_ok   = (tbl_pin[src_idx_q] == pin_q);
  assign amt_zero = (amt_q == '0);
  assign bad_op   = (op_q > OP_VERIFY)
                 || (amt_zero && (op_q == OP_DEPOSIT || op_q == OP_WITHDRAW || op_q == OP_TRANSFER))
                 || (op_q == OP_TRANSFER && dst_q == acct_q);

  assign src_ext  = {1'b0, tbl_bal[src_idx_q]};
  assign dst_ext  = {1'b0, tbl_bal[dst_idx_q]};
  assign amt_ext  = (DATA_W + 1)'(amt_q);
  assign src_sum  = src_ext + amt_ext;
  assign src_diff = src_ext - amt_ext;
  assign dst_sum  = dst_ext + amt_ext;

  // Error priority is fixed by the if-chain order; arithmetic is only reached when all pass.
  always_comb begin
    exec_status  = STAT_OK;
    new_src      = tbl_bal[src_idx_q];
    new_dst      = tbl_bal[dst_idx_q];
    exec_dst_bal = '0;
    wr_src       = 1'b0;
    wr_dst       = 1'b0;
    if (!src_hit_q)                           exec_status = STAT_NO_ACCT;
    else if (src_locked)                      exec_status = STAT_LOCKED;
    else if (!pin_ok)                         exec_status = STAT_BAD_PIN;
    else if (bad_op)                          exec_status = STAT_BAD_OP;
    else if (op_q == OP_TRANSFER && !dst_hit_q) exec_status = STAT_NO_DST;
    else begin
      case (op_q)
        OP_DEPOSIT: begin
          if (src_sum[DATA_W]) exec_status = STAT_OVERFLOW;
          else begin
            new_src = src_sum[DATA_W-1:0];
            wr_src  = 1'b1;
          end
        end
        OP_WITHDRAW: begin
          if (amt_ext > src_ext) exec_status = STAT_INSUFF;
          else begin
            new_src = src_diff[DATA_W-1:0];
            wr_src  = 1'b1;
          end
        end
        OP_TRANSFER: begin
          if (amt_ext > src_ext)     exec_status = STAT_INSUFF;
          else if (dst_sum[DATA_W])  exec_status = STAT_OVERFLOW;
          else begin
            new_src = src_diff[DATA_W-1:0];
            new_dst = dst_sum[DATA_W-1:0];
            wr_src  = 1'b1;
            wr_dst  = 1'b1;
          end
          exec_dst_bal = new_dst;
        end
        default: ;
      endcase
    end
  end

`ifdef ATM_BANK_LOCKOUT_EN
  logic [1:0] bad_cnt [NUM_ACCTS];
  logic       locked  [NUM_ACCTS];

  assign src_locked = locked[src_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bad_cnt[i] <= '0;
        locked[i]  <= 1'b0;
      end
    end else if (state == S_EXEC && src_hit_q && !src_locked) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        if (IDX_W'(i) == src_idx_q) begin
          if (pin_ok) bad_cnt[i] <= '0;
          else begin
            bad_cnt[i] <= bad_cnt[i] + 2'd1;
            if (bad_cnt[i] == 2'd2) locked[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign src_locked = 1'b0;
`endif

  // NOTE: the account table is small and must come back to known contents, so it is
  // built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        tbl_acct[i] <= DATA_W'(rst_acct(i));
        tbl_pin[i]  <= DATA_W'(rst_acct(i));
        tbl_bal[i]  <= DATA_W'(rst_bal(i));
      end
      op_q            <= '0;
      acct_q          <= '0;
      pin_q           <= '0;
      dst_q           <= '0;
      amt_q           <= '0;
      src_hit_q       <= 1'b0;
      dst_hit_q       <= 1'b0;
      src_idx_q       <= '0;
      dst_idx_q       <= '0;
      rsp_status      <= '0;
      rsp_balance     <= '0;
      rsp_dst_balance <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this block
      // order-independent within the clock edge.
      if (state == S_IDLE && req_valid) begin
        op_q   <= req_op;
        acct_q <= req_acct;
        pin_q  <= req_pin;
        dst_q  <= req_dst;
        amt_q  <= req_amount;
      end
      if (state == S_LOOKUP) begin
        src_hit_q <= src_hit;
        dst_hit_q <= dst_hit;
        src_idx_q <= src_idx;
        dst_idx_q <= dst_idx;
      end
      if (state == S_EXEC) begin
        for (int i = 0; i < NUM_ACCTS; i++) begin
          if (wr_src && IDX_W'(i) == src_idx_q)      tbl_bal[i] <= new_src;
          else if (wr_dst && IDX_W'(i) == dst_idx_q) tbl_bal[i] <= new_dst;
        end
        rsp_status      <= exec_status;
        rsp_balance     <= src_hit_q ? new_src : '0;
        rsp_dst_balance <= exec_dst_bal;
      end
    end
  end

endmodule

// File: tb/tb_atm_bank_host.sv
// Directed self-checking bench for atm_bank_host; expectations are hand-computed constants.
module tb_atm_bank_host;
  import atm_bank_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req_op, rsp_status;
  logic [11:0] req_acct, req_pin, req_dst, rsp_balance, rsp_dst_balance;
  logic [5:0]  req_amount;

  int checks = 0;
  int errors = 0;

  atm_bank_host dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_acct(req_acct), .req_pin(req_pin), .req_dst(req_dst), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .rsp_dst_balance(rsp_dst_balance)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_status", rsp_status, 0);
    check("rst_bal", rsp_balance, 0);
    check("rst_dst_bal", rsp_dst_balance, 0);
    step();
    rst = 1'b0;
  endtask

  // One complete request/response; hold>0 stalls rsp_ready and keeps a request pending.
  task automatic txn(input string tag, input logic [2:0] op, input logic [11:0] acct,
                     input logic [11:0] pin, input logic [11:0] dst, input logic [5:0] amt,
                     input logic [2:0] exp_st, input logic [11:0] exp_bal,
                     input logic [11:0] exp_dst, input int hold);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, "_ready"}, req_ready, 1);
    req_op     = op;
    req_acct   = acct;
    req_pin    = pin;
    req_dst    = dst;
    req_amount = amt;
    req_valid  = 1'b1;
    if (hold > 0) rsp_ready = 1'b0;
    step();
    if (hold == 0) req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 3);
    check({tag, "_status"}, rsp_status, exp_st);
    check({tag, "_bal"}, rsp_balance, exp_bal);
    check({tag, "_dst_bal"}, rsp_dst_balance, exp_dst);
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, "_hold_valid"}, rsp_valid, 1);
      check({tag, "_hold_ready"}, req_ready, 0);
      check({tag, "_hold_status"}, rsp_status, exp_st);
      check({tag, "_hold_bal"}, rsp_balance, exp_bal);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    check({tag, "_done"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = '0; req_acct = '0; req_pin = '0; req_dst = '0; req_amount = '0;
    do_reset();

    txn("wd_basic", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h10, STAT_OK, 12'h447, 12'h000, 0);
    txn("xfer_basic", OP_TRANSFER, 12'h456, 12'h456, 12'h789, 6'h20, STAT_OK, 12'h88E, 12'hD25, 0);
    txn("verify", OP_VERIFY, 12'h789, 12'h789, 12'h000, 6'h00, STAT_OK, 12'hD25, 12'h000, 0);
    txn("bad_pin", OP_BALANCE, 12'h456, 12'h000, 12'h000, 6'h00, STAT_BAD_PIN, 12'h88E, 12'h000, 0);

    do_reset();
    for (int k = 1; k <= 17; k++)
      txn("wd_run", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h3F, STAT_OK,
          12'(12'h457 - k * 12'h03F), 12'h000, 0);
    txn("wd_insuff", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h3F, STAT_INSUFF, 12'h028, 12'h000, 0);
    txn("wd_exact", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h28, STAT_OK, 12'h000, 12'h000, 0);
    txn("wd_empty", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h01, STAT_INSUFF, 12'h000, 12'h000, 0);

    for (int k = 1; k <= 12; k++)
      txn("dep_run", OP_DEPOSIT, 12'h789, 12'h789, 12'h000, 6'h3F, STAT_OK,
          12'(12'hD05 + k * 12'h03F), 12'h000, 0);
    txn("dep_ovf", OP_DEPOSIT, 12'h789, 12'h789, 12'h000, 6'h3F, STAT_OVERFLOW, 12'hFF9, 12'h000, 0);

    txn("no_acct", OP_BALANCE, 12'h999, 12'h999, 12'h000, 6'h00, STAT_NO_ACCT, 12'h000, 12'h000, 0);
    txn("no_dst", OP_TRANSFER, 12'h456, 12'h456, 12'h555, 6'h01, STAT_NO_DST, 12'h8AE, 12'h000, 0);
    txn("op_110", 3'b110, 12'h456, 12'h456, 12'h000, 6'h01, STAT_BAD_OP, 12'h8AE, 12'h000, 0);
    txn("dep_zero", OP_DEPOSIT, 12'h456, 12'h456, 12'h000, 6'h00, STAT_BAD_OP, 12'h8AE, 12'h000, 0);
    txn("xfer_self", OP_TRANSFER, 12'h456, 12'h456, 12'h456, 6'h01, STAT_BAD_OP, 12'h8AE, 12'h000, 0);
    txn("xfer_ovf", OP_TRANSFER, 12'h456, 12'h456, 12'h789, 6'h07, STAT_OVERFLOW, 12'h8AE, 12'hFF9, 0);
    txn("xfer_max", OP_TRANSFER, 12'h456, 12'h456, 12'h789, 6'h06, STAT_OK, 12'h8A8, 12'hFFF, 0);

    txn("hold", OP_BALANCE, 12'h456, 12'h456, 12'h000, 6'h00, STAT_OK, 12'h8A8, 12'h000, 5);

    // Reset lands on the edge that would have committed this withdraw.
    req_op = OP_WITHDRAW; req_acct = 12'h456; req_pin = 12'h456; req_amount = 6'h3F;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_ready", req_ready, 0);
    rst = 1'b0;
    step();
    txn("after_rst", OP_BALANCE, 12'h456, 12'h456, 12'h000, 6'h00, STAT_OK, 12'h8AE, 12'h000, 0);

    for (int k = 0; k < 3; k++)
      txn("lock_bad", OP_BALANCE, 12'h123, 12'h000, 12'h000, 6'h00, STAT_BAD_PIN, 12'h457, 12'h000, 0);
`ifdef ATM_BANK_LOCKOUT_EN
    txn("lock_good", OP_BALANCE, 12'h123, 12'h123, 12'h000, 6'h00, STAT_LOCKED, 12'h457, 12'h000, 0);
    txn("lock_wd", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h01, STAT_LOCKED, 12'h457, 12'h000, 0);
`else
    txn("lock_good", OP_BALANCE, 12'h123, 12'h123, 12'h000, 6'h00, STAT_OK, 12'h457, 12'h000, 0);
    txn("lock_wd", OP_WITHDRAW, 12'h123, 12'h123, 12'h000, 6'h01, STAT_OK, 12'h456, 12'h000, 0);
`endif
    txn("other_acct", OP_BALANCE, 12'h456, 12'h456, 12'h000, 6'h00, STAT_OK, 12'h8AE, 12'h000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
